// File: rtl/calc_pkg.sv
// calc_pkg: shared types and width helpers for the arithmetic unit
package calc_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t;
  function automatic int bitcnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bit_down_counter.sv
// bit_down_counter: loadable down counter with clear and zero/one flags
module bit_down_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         clr_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         one
);
  // clear wins over load, load wins over decrement; never wraps below zero
  always_ff @(posedge CLK)
    if (!clr_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
  assign one  = cnt == W'(1);
endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-in/serial-out word transmitter with shift strobe
module serial_word_tx
  import calc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N-1:0]           D,
  input  logic                   START,
  input  logic                   ABORT,
  output logic                   READY,
  output logic                   SerOut,
  output logic                   SH,
  output logic                   DONE,
  output logic [bitcnt_w(N)-1:0] BITCNT
);
  localparam int W = bitcnt_w(N);
  tx_state_t state, state_nxt;
  logic [N-1:0] word, word_nxt;
  logic accept, kill, cnt_one, cnt_zero, bit_nxt;
  // next state, next shift word and the bit that will sit on SerOut next cycle
  always_comb begin
    accept    = state == TX_IDLE && START;
    kill      = state == TX_SHIFT && ABORT;
    state_nxt = accept ? TX_SHIFT :
                kill ? TX_IDLE :
                (state == TX_SHIFT && cnt_one) ? TX_DONE :
                state == TX_DONE ? TX_IDLE : state;
    word_nxt  = accept ? D :
                state == TX_SHIFT ? (MSB_FIRST ? word << 1 : word >> 1) : word;
    bit_nxt   = MSB_FIRST ? word_nxt[N-1] : word_nxt[0];
  end
  // state register
  always_ff @(posedge CLK)
    if (!RST_N) state <= TX_IDLE;
    else state <= state_nxt;
  // shift word, captured only on accept so later D changes cannot leak in
  always_ff @(posedge CLK)
    if (!RST_N) word <= '0;
    else word <= word_nxt;
  // outputs registered from the next state so they line up with it
  always_ff @(posedge CLK)
    if (!RST_N) begin
      READY  <= 1'b1;
      SH     <= 1'b0;
      SerOut <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      READY  <= state_nxt == TX_IDLE;
      SH     <= state_nxt == TX_SHIFT;
      SerOut <= state_nxt == TX_SHIFT && bit_nxt;
      DONE   <= state_nxt == TX_DONE;
    end
  bit_down_counter #(.W(W)) u_cnt (
    .CLK     (CLK),
    .clr_n   (RST_N && !kill),
    .load    (accept),
    .dec     (state == TX_SHIFT),
    .load_val(W'(N)),
    .cnt     (BITCNT),
    .zero    (cnt_zero),
    .one     (cnt_one)
  );
endmodule
